// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register specifiers, word type.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package y86_pkg;

  typedef logic [63:0] word_t;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  localparam int NUM_REGS = 15;

endpackage

// File: rtl/regfile.sv
// Y86-64 architectural register file: 15x64 storage, two read ports, two write ports.
// Latency: reads combinational (old value during a write); writes visible after the edge.
// Backpressure: none; one write pair accepted every cycle.
// Ports: clk/reset (sync, active-high); src_a/src_b -> val_a/val_b read ports;
//        we gates both write ports; dst_e/val_e and dst_m/val_m write ports (M wins on clash).
module regfile
  import y86_pkg::*;
#(
  parameter word_t RSP_INIT = 64'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] src_a,
  input  logic [3:0] src_b,
  output word_t      val_a,
  output word_t      val_b,
  input  logic       we,
  input  logic [3:0] dst_e,
  input  word_t      val_e,
  input  logic [3:0] dst_m,
  input  word_t      val_m
);

  word_t regs [NUM_REGS];

  // RNONE has no storage behind it and always reads as zero.
  assign val_a = (src_a == RNONE) ? 64'd0 : regs[src_a];
  assign val_b = (src_b == RNONE) ? 64'd0 : regs[src_b];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == int'(RRSP)) ? RSP_INIT : 64'd0;
      end
    end else if (we) begin
      if (dst_e != RNONE) regs[dst_e] <= val_e;
      // Issued after port E so the later non-blocking assignment wins when
      // both ports target the same register (popq %rsp).
      if (dst_m != RNONE) regs[dst_m] <= val_m;
    end
  end

endmodule

// File: rtl/writeback_regfile.sv
// SEQ Y86-64 write-back: destination decode, register commit, halt flag, write counter.
// Latency: dstE/dstM/valA/valB combinational; commits land on the next rising edge.
// Backpressure: none; one instruction retires per cycle while valid is high.
// Ports: valid/icode/rA/rB/cnd/valE/valM from the retiring instruction; srcA/srcB -> valA/valB
//        for decode; dstE/dstM computed destinations; halted sticky flag; wr_count write tally.
module writeback_regfile
  import y86_pkg::*;
#(
  parameter word_t RSP_INIT = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  word_t       valE,
  input  word_t       valM,
  input  logic [3:0]  srcA,
  input  logic [3:0]  srcB,
  output word_t       valA,
  output word_t       valB,
  output logic [3:0]  dstE,
  output logic [3:0]  dstM,
  output logic        halted,
  output logic [31:0] wr_count
);

  logic       we;
  logic [1:0] wr_inc;

  always_comb begin
    dstE = RNONE;
    unique case (icode)
      I_RRMOVQ:                          dstE = cnd ? rB : RNONE;
      I_IRMOVQ, I_OPQ:                   dstE = rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:    dstE = RRSP;
      default:                           dstE = RNONE;
    endcase
  end

  always_comb begin
    dstM = RNONE;
    if (icode == I_MRMOVQ || icode == I_POPQ) dstM = rA;
  end

  // Invalid icodes and halt decode to RNONE on both ports, so they commit nothing.
  assign we = valid & ~halted;

  // Two distinct live destinations count twice; a shared one counts once.
  always_comb begin
    wr_inc = 2'd0;
    if (dstE != RNONE && dstM != RNONE && dstE != dstM) wr_inc = 2'd2;
    else if (dstE != RNONE || dstM != RNONE)            wr_inc = 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      halted   <= 1'b0;
      wr_count <= 32'd0;
    end else if (we) begin
      if (icode == I_HALT) halted <= 1'b1;
      wr_count <= wr_count + 32'(wr_inc);
    end
  end

  regfile #(
    .RSP_INIT (RSP_INIT)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .src_a (srcA),
    .src_b (srcB),
    .val_a (valA),
    .val_b (valB),
    .we    (we),
    .dst_e (dstE),
    .val_e (valE),
    .dst_m (dstM),
    .val_m (valM)
  );

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile with RSP_INIT = 64'h100.
// Inputs change 1ns after each rising edge; outputs are sampled before the next edge.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [3:0]  icode, rA, rB;
  logic        cnd;
  logic [63:0] valE, valM;
  logic [3:0]  srcA, srcB;
  logic [63:0] valA, valB;
  logic [3:0]  dstE, dstM;
  logic        halted;
  logic [31:0] wr_count;

  int checks = 0;
  int errors = 0;

  writeback_regfile #(.RSP_INIT(64'h100)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid    (valid),
    .icode    (icode),
    .rA       (rA),
    .rB       (rB),
    .cnd      (cnd),
    .valE     (valE),
    .valM     (valM),
    .srcA     (srcA),
    .srcB     (srcB),
    .valA     (valA),
    .valB     (valB),
    .dstE     (dstE),
    .dstM     (dstM),
    .halted   (halted),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
    valE = 64'd0; valM = 64'd0;
  endtask

  task automatic test_reset();
    logic [63:0] exp;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 15; i++) begin
      srcA = 4'(i); srcB = 4'(i);
      exp = (i == 4) ? 64'h100 : 64'd0;
      #1;
      checks++;
      if (valA !== exp) begin errors++; $display("FAIL reset_valA r%0d got %h exp %h", i, valA, exp); end
      checks++;
      if (valB !== exp) begin errors++; $display("FAIL reset_valB r%0d got %h exp %h", i, valB, exp); end
    end
    srcA = 4'hF; #1;
    checks++;
    if (valA !== 64'd0) begin errors++; $display("FAIL rnone_read got %h exp 0", valA); end
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
    checks++;
    if (wr_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", wr_count); end
  endtask

  task automatic test_irmov_opq();
    srcB = 4'd2;
    valid = 1'b1; icode = 4'h3; rA = 4'hF; rB = 4'd2; valE = 64'd5; #1;
    checks++;
    if (dstE !== 4'd2 || dstM !== 4'hF) begin errors++; $display("FAIL irmov_dst got %h/%h exp 2/f", dstE, dstM); end
    step();
    checks++;
    if (valB !== 64'd5) begin errors++; $display("FAIL irmov_write got %h exp 5", valB); end
    icode = 4'h6; valE = 64'd9; #1;
    checks++;
    if (valB !== 64'd5) begin errors++; $display("FAIL same_cycle_read got %h exp 5", valB); end
    step();
    idle(); #1;
    checks++;
    if (valB !== 64'd9) begin errors++; $display("FAIL opq_write got %h exp 9", valB); end
    checks++;
    if (wr_count !== 32'd2) begin errors++; $display("FAIL opq_count got %0d exp 2", wr_count); end
  endtask

  task automatic test_cmov();
    srcA = 4'd3;
    // Not valid: no state change even though dst decodes to a register.
    valid = 1'b0; icode = 4'h3; rB = 4'd3; valE = 64'hDEAD; step();
    checks++;
    if (valA !== 64'd0) begin errors++; $display("FAIL invalid_no_write got %h exp 0", valA); end
    valid = 1'b1; icode = 4'h2; rA = 4'd1; rB = 4'd3; cnd = 1'b0; valE = 64'd7; #1;
    checks++;
    if (dstE !== 4'hF) begin errors++; $display("FAIL cmov_nc_dst got %h exp f", dstE); end
    step();
    idle(); #1;
    checks++;
    if (valA !== 64'd0) begin errors++; $display("FAIL cmov_nc_reg got %h exp 0", valA); end
    checks++;
    if (wr_count !== 32'd2) begin errors++; $display("FAIL cmov_nc_count got %0d exp 2", wr_count); end
    valid = 1'b1; icode = 4'h2; rA = 4'd1; rB = 4'd3; cnd = 1'b1; valE = 64'd7; #1;
    checks++;
    if (dstE !== 4'd3) begin errors++; $display("FAIL cmov_c_dst got %h exp 3", dstE); end
    step();
    idle(); #1;
    checks++;
    if (valA !== 64'd7) begin errors++; $display("FAIL cmov_c_reg got %h exp 7", valA); end
    checks++;
    if (wr_count !== 32'd3) begin errors++; $display("FAIL cmov_c_count got %0d exp 3", wr_count); end
  endtask

  task automatic test_popq_rsp();
    srcA = 4'd4;
    valid = 1'b1; icode = 4'hB; rA = 4'd4; rB = 4'hF; valE = 64'h108; valM = 64'hAA; #1;
    checks++;
    if (dstE !== 4'd4 || dstM !== 4'd4) begin errors++; $display("FAIL popq_dst got %h/%h exp 4/4", dstE, dstM); end
    step();
    idle(); #1;
    checks++;
    if (valA !== 64'hAA) begin errors++; $display("FAIL popq_rsp got %h exp aa", valA); end
    checks++;
    if (wr_count !== 32'd4) begin errors++; $display("FAIL popq_count got %0d exp 4", wr_count); end
  endtask

  task automatic test_mrmov();
    srcA = 4'd1;
    valid = 1'b1; icode = 4'h5; rA = 4'd1; rB = 4'd0; valE = 64'h77; valM = 64'h55; #1;
    checks++;
    if (dstE !== 4'hF || dstM !== 4'd1) begin errors++; $display("FAIL mrmov_dst got %h/%h exp f/1", dstE, dstM); end
    step();
    idle(); #1;
    checks++;
    if (valA !== 64'h55) begin errors++; $display("FAIL mrmov_reg got %h exp 55", valA); end
    checks++;
    if (wr_count !== 32'd5) begin errors++; $display("FAIL mrmov_count got %0d exp 5", wr_count); end
    // Invalid icode: no write, no halt, no count.
    valid = 1'b1; icode = 4'hC; rA = 4'd1; rB = 4'd1; valE = 64'h1; valM = 64'h2; step();
    idle(); #1;
    checks++;
    if (valA !== 64'h55 || wr_count !== 32'd5 || halted !== 1'b0) begin
      errors++; $display("FAIL invalid_icode got %h/%0d/%b exp 55/5/0", valA, wr_count, halted);
    end
  endtask

  task automatic test_halt();
    srcA = 4'd6;
    valid = 1'b1; icode = 4'h0; step();
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL halt_set got %b exp 1", halted); end
    icode = 4'h3; rB = 4'd6; valE = 64'd1; step();
    idle(); #1;
    checks++;
    if (valA !== 64'd0) begin errors++; $display("FAIL halt_no_write got %h exp 0", valA); end
    checks++;
    if (wr_count !== 32'd5) begin errors++; $display("FAIL halt_count got %0d exp 5", wr_count); end
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky got %b exp 1", halted); end
    // Reset mid-stream also drops a simultaneous write.
    reset = 1'b1; valid = 1'b1; icode = 4'h3; rB = 4'd2; valE = 64'h33; step();
    reset = 1'b0; idle(); #1;
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b exp 0", halted); end
    checks++;
    if (wr_count !== 32'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", wr_count); end
    for (int i = 0; i < 15; i++) begin
      srcB = 4'(i); #1;
      checks++;
      if (valB !== ((i == 4) ? 64'h100 : 64'd0)) begin
        errors++; $display("FAIL rst_reg r%0d got %h", i, valB);
      end
    end
  endtask

  initial begin
    reset = 1'b1; srcA = 4'd0; srcB = 4'd0;
    idle();
    test_reset();
    test_irmov_opq();
    test_cmov();
    test_popq_rsp();
    test_mrmov();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
